audio_fifo_bridge: RTL
======================

// Module: audio_fifo_bridge
// PURPOSE
//  Parametrised N-channel bridge between the I2S codec interface and per-channel sample FIFOs.
//  - Capture path: writes codec ADC strobes into write FIFOs; drops and counts overflows.
//  - Playback path: converts DAC sample requests into FIFO reads, handles read latency,
//    detects underruns and holds one output register per channel.
//  - Sits in the fabric top level between i2s and the cpu_sys FIFO ports, clocked by AMSCK.
// PARAMETERS
//  NCH          2   number of audio channels (1..8)
//  DATA_W       24  sample width, bits
//  RD_LAT       1   FIFO rd_en -> rd_data latency, cycles (1..4)
//  UNDERRUN_HLD 0   0: underrun loads zero; 1: underrun keeps the previous sample
//  CNT_W        16  statistics counter width
// PORTS
//  AMSCK      in   1            audio master clock; all logic on its rising edge
//  rst        in   1            reset, asynchronous, active-high
//  adc_data   in   DATA_W       captured sample, shared by all channels
//  adc_valid  in   NCH          1-cycle strobe per channel: adc_data belongs to channel c
//  wr_en      out  NCH          write-FIFO write enable
//  wr_data    out  NCH*DATA_W   write-FIFO data; channel c occupies [c*DATA_W +: DATA_W]
//  wr_full    in   NCH          write-FIFO full
//  dac_rd     in   NCH          1-cycle request for the next playback sample of channel c
//  rd_en      out  NCH          read-FIFO read enable
//  rd_data    in   NCH*DATA_W   read-FIFO data, valid RD_LAT cycles after rd_en
//  rd_empty   in   NCH          read-FIFO empty
//  mute       in   NCH          force zero into the playback register of channel c
//  dac_data   out  NCH*DATA_W   playback sample registers, to i2s
//  dac_valid  out  NCH          1-cycle pulse: dac_data slot c updated
//  rd_collide out  NCH          sticky: dac_rd arrived while a read was still in flight
//  clr_stats  in   1            synchronous clear of counters and rd_collide
//  ovf_cnt    out  NCH*CNT_W    per-channel overflow count (dropped ADC samples)
//  udf_cnt    out  NCH*CNT_W    per-channel underrun count
// BEHAVIOUR
//  Reset: all registers 0; dac_data=0, dac_valid=0, rd_collide=0, counters=0, pipeline cleared.
//    Asserting rst mid-read discards the in-flight read; no dac_valid is produced for it.
//  Capture (combinational, zero latency):
//    wr_en[c]=adc_valid[c]&~wr_full[c]; wr_data slot c = adc_data.
//    Several adc_valid bits in one cycle are legal; each such channel writes the same word.
//    adc_valid[c]&wr_full[c]: sample dropped, ovf_cnt[c]+1.
//  Playback, per channel, pend[c] = OR of RD_LAT-deep in-flight shift register:
//    Accept: cycle t, dac_rd[c]&~pend[c].
//      ~rd_empty: rd_en[c]=1 in cycle t (combinational); marker tagged DATA.
//      rd_empty: rd_en stays 0; marker tagged UNDERRUN; udf_cnt[c]+1.
//    Marker reaches the end of the pipe at the edge ending cycle t+RD_LAT:
//      DATA: slot loads rd_data. UNDERRUN: slot loads 0 (UNDERRUN_HLD=0) or holds (=1).
//      mute[c]=1 at that edge: slot loads 0 regardless of tag.
//      dac_valid[c]=1 in cycle t+RD_LAT+1 only.
//    Reject: dac_rd[c]&pend[c]: request ignored (no rd_en, no marker); rd_collide[c] set.
//  Counters saturate at 2^CNT_W-1 and never wrap.
//    clr_stats wins over a same-cycle increment: result 0. Also clears rd_collide.
//  Channels are fully independent. No cross-channel arbitration; simultaneous requests all served.
// CONFIGURATION
//  AUDIO_FIFO_BRIDGE_STATS_EN defined: ovf_cnt/udf_cnt counters are built as specified.
//  Not defined: no counter flops; ovf_cnt=0 and udf_cnt=0 constantly.
//    rd_collide, underrun and drop behaviour are unchanged.
// TESTING
//  1 rst=1 mid-read, then release -> all outputs 0; pulse dac_rd[0] with FIFO holding 0x123456,
//    RD_LAT=1 -> rd_en[0] same cycle; dac_data[23:0]=0x123456 with dac_valid[0] one cycle later.
//  2 adc_valid=2'b11, adc_data=0xABCDEF, wr_full=2'b10 -> wr_en=2'b01;
//    ovf_cnt ch1=1, ch0=0 (STATS_EN defined).
//  3 dac_rd[1] with rd_empty[1]=1, slot holds 0x000777 -> rd_en[1]=0; udf_cnt ch1=1; dac_valid[1] pulses.
//    Slot becomes 0 (UNDERRUN_HLD=0) or stays 0x000777 (UNDERRUN_HLD=1).
//  4 RD_LAT=3, dac_rd[0] on cycles t and t+1 -> one rd_en; rd_collide[0]=1;
//    dac_valid[0] only at t+4; clr_stats -> rd_collide=0.
//  5 CNT_W=4, 20 overflows on ch0 -> ovf_cnt ch0=15.
//    clr_stats together with a drop -> 0. Build without STATS_EN -> counters read 0.
//  6 mute[0]=1, FIFO word 0x7FFFFF read -> dac_data slot0=0, dac_valid[0] pulses, FIFO still popped.

Source files
------------

// File: rtl/audio_fifo_bridge.sv
// audio_fifo_bridge: N-channel I2S <-> sample FIFO bridge on AMSCK.
// Optional counters: define AUDIO_FIFO_BRIDGE_STATS_EN to build ovf_cnt/udf_cnt.
module audio_fifo_bridge #(
  parameter int NCH          = 2,
  parameter int DATA_W       = 24,
  parameter int RD_LAT       = 1,
  parameter int UNDERRUN_HLD = 0,
  parameter int CNT_W        = 16
) (
  input  logic                  AMSCK,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic [NCH-1:0]        adc_valid,
  output logic [NCH-1:0]        wr_en,
  output logic [NCH*DATA_W-1:0] wr_data,
  input  logic [NCH-1:0]        wr_full,
  input  logic [NCH-1:0]        dac_rd,
  output logic [NCH-1:0]        rd_en,
  input  logic [NCH*DATA_W-1:0] rd_data,
  input  logic [NCH-1:0]        rd_empty,
  input  logic [NCH-1:0]        mute,
  output logic [NCH*DATA_W-1:0] dac_data,
  output logic [NCH-1:0]        dac_valid,
  output logic [NCH-1:0]        rd_collide,
  input  logic                  clr_stats,
  output logic [NCH*CNT_W-1:0]  ovf_cnt,
  output logic [NCH*CNT_W-1:0]  udf_cnt
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch

    // Marker pipe: r_pipe flags an in-flight request, r_tag is 1 for DATA
    logic [RD_LAT-1:0] r_pipe;
    logic [RD_LAT-1:0] r_tag;
    logic [DATA_W-1:0] r_dac;
    logic              r_dv;
    logic              r_col;
    logic              w_pend;
    logic              w_acc;
    logic              w_done;
    logic              w_done_data;

    assign w_pend      = |r_pipe;
    assign w_acc       = dac_rd[c] & ~w_pend;
    assign w_done      = r_pipe[RD_LAT-1];
    assign w_done_data = r_tag[RD_LAT-1];

    // Capture path is purely combinational
    assign wr_en[c] = adc_valid[c] & ~wr_full[c];
    assign wr_data[c*DATA_W +: DATA_W] = adc_data;

    // FIFO pop only when an accepted request finds data
    assign rd_en[c] = w_acc & ~rd_empty[c];

    assign dac_data[c*DATA_W +: DATA_W] = r_dac;
    assign dac_valid[c]  = r_dv;
    assign rd_collide[c] = r_col;

    // Shift request markers along the read-latency pipe
    always_ff @(posedge AMSCK or posedge rst) begin
      if (rst) begin
        r_pipe <= '0;
        r_tag  <= '0;
      end else begin
        r_pipe[0] <= w_acc;
        r_tag[0]  <= w_acc & ~rd_empty[c];
        for (int k = 1; k < RD_LAT; k++) begin
          r_pipe[k] <= r_pipe[k-1];
          r_tag[k]  <= r_tag[k-1];
        end
      end
    end

    // Playback register update when a marker leaves the pipe
    always_ff @(posedge AMSCK or posedge rst) begin
      if (rst) begin
        r_dac <= '0;
        r_dv  <= 1'b0;
      end else begin
        r_dv <= w_done;
        if (w_done) begin
          if (mute[c]) begin
            r_dac <= '0;
          end else if (w_done_data) begin
            r_dac <= rd_data[c*DATA_W +: DATA_W];
          end else if (UNDERRUN_HLD == 0) begin
            r_dac <= '0;
          end
        end
      end
    end

    // Sticky flag for requests arriving while a read is in flight
    always_ff @(posedge AMSCK or posedge rst) begin
      if (rst) begin
        r_col <= 1'b0;
      end else if (clr_stats) begin
        r_col <= 1'b0;
      end else if (dac_rd[c] & w_pend) begin
        r_col <= 1'b1;
      end
    end

`ifdef AUDIO_FIFO_BRIDGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_ovf;
    logic [CNT_W-1:0] r_udf;
    logic             w_ovf_inc;
    logic             w_udf_inc;

    assign w_ovf_inc = adc_valid[c] & wr_full[c];
    assign w_udf_inc = w_acc & rd_empty[c];

    assign ovf_cnt[c*CNT_W +: CNT_W] = r_ovf;
    assign udf_cnt[c*CNT_W +: CNT_W] = r_udf;

    // Saturating drop counter; clear beats increment
    always_ff @(posedge AMSCK or posedge rst) begin
      if (rst) begin
        r_ovf <= '0;
      end else if (clr_stats) begin
        r_ovf <= '0;
      end else if (w_ovf_inc && (r_ovf != CNT_MAX)) begin
        r_ovf <= r_ovf + CNT_ONE;
      end
    end

    // Saturating underrun counter; clear beats increment
    always_ff @(posedge AMSCK or posedge rst) begin
      if (rst) begin
        r_udf <= '0;
      end else if (clr_stats) begin
        r_udf <= '0;
      end else if (w_udf_inc && (r_udf != CNT_MAX)) begin
        r_udf <= r_udf + CNT_ONE;
      end
    end
`else
    assign ovf_cnt[c*CNT_W +: CNT_W] = '0;
    assign udf_cnt[c*CNT_W +: CNT_W] = '0;
`endif

  end

endmodule
